// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states,
// division special-case constants and op-decoding helpers.
package rv32m_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
  localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV    = 3'd4;
  localparam logic [OP_W-1:0] OP_DIVU   = 3'd5;
  localparam logic [OP_W-1:0] OP_REM    = 3'd6;
  localparam logic [OP_W-1:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Quotient for divide-by-zero, and the most negative value for signed overflow
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] MIN_NEG  = 32'h8000_0000;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op >= OP_DIV);
  endfunction

  function automatic logic op_is_rem(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op_a_signed(input logic [OP_W-1:0] op);
    return (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide on magnitudes, sign fix-up at the end, start/busy/done handshake.
module rv32m_muldiv
  import rv32m_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;

  logic                a_neg_c;
  logic                b_neg_c;
  logic [XLEN-1:0]     mag_a_c;
  logic [XLEN-1:0]     mag_b_c;
  logic                div_zero_c;
  logic                div_ovf_c;
  logic                div_op;
  logic [XLEN:0]       add_a;
  logic [XLEN:0]       add_b;
  logic [XLEN+1:0]     add_sum;
  logic [2*XLEN-1:0]   sel_c;
  logic [2*XLEN-1:0]   fixed_c;
  logic [XLEN-1:0]     res_c;

  // Accept-time decode: operand magnitudes and division special cases
  always_comb begin
    a_neg_c    = op_a_signed(op) & src_a[XLEN-1];
    b_neg_c    = op_b_signed(op) & src_b[XLEN-1];
    mag_a_c    = a_neg_c ? -src_a : src_a;
    mag_b_c    = b_neg_c ? -src_b : src_b;
    div_zero_c = op_is_div(op) && (src_b == '0);
    div_ovf_c  = op_is_div(op) && op_a_signed(op) && (src_a == MIN_NEG) && (src_b == ALL_ONES);
  end

  assign div_op = op_is_div(op_q);

  // Shared 33-bit adder: add multiplicand, or subtract divisor from the shifted remainder
  always_comb begin
    if (div_op) begin
      add_a = acc[2*XLEN-1:XLEN-1];
      add_b = ~{1'b0, opnd};
    end else begin
      add_a = {1'b0, acc[2*XLEN-1:XLEN]};
      add_b = {1'b0, opnd};
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + (XLEN+2)'(div_op);
  end

  // Result selection and sign correction; special cases arrive here with neg_q clear
  always_comb begin
    if (div_op) begin
      sel_c = {{XLEN{1'b0}}, (op_is_rem(op_q) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0])};
    end else begin
      sel_c = acc;
    end
    fixed_c = neg_q ? -sel_c : sel_c;
    if (div_op || (op_q == OP_MUL)) begin
      res_c = fixed_c[XLEN-1:0];
    end else begin
      res_c = fixed_c[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
    end else begin
      done <= 1'b0;
      if (kill && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !kill) begin
              op_q <= op;
              busy <= 1'b1;
              cnt  <= '0;
              opnd <= mag_b_c;
              if (div_zero_c || div_ovf_c) begin
                // Preload the answer where FIX will pick it up: remainder high, quotient low
                state <= FIX;
                neg_q <= 1'b0;
                acc   <= div_zero_c ? {src_a, ALL_ONES} : {{XLEN{1'b0}}, MIN_NEG};
              end else begin
                state <= CALC;
                neg_q <= op_is_rem(op) ? a_neg_c : (a_neg_c ^ b_neg_c);
                acc   <= {{XLEN{1'b0}}, mag_a_c};
              end
            end
          end
          CALC: begin
            cnt <= cnt + CNT_W'(1);
            if (div_op) begin
              if (add_sum[XLEN+1]) begin
                acc <= {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
              end else begin
                acc <= {acc[2*XLEN-2:0], 1'b0};
              end
            end else begin
              if (acc[0]) begin
                acc <= {add_sum[XLEN:0], acc[XLEN-1:1]};
              end else begin
                acc <= {1'b0, acc[2*XLEN-1:1]};
              end
            end
            if (cnt == '1) begin
              state <= FIX;
            end
          end
          FIX: begin
            result <= res_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv.sv
// Scoreboard bench for rv32m_muldiv: random and directed ops against an arithmetic
// reference model, with done-cycle timing, busy window, kill and reset checks.
module tb_rv32m_muldiv;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] last_res = 32'd0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];

  rv32m_muldiv dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int qa, qb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = int'(a);
    qb = int'(b);
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(qa / qb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(qa % qb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard on each done pulse, checks busy while an op is pending
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d result %h", cyc, result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (result !== e.res) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h got %h expected %h", e.op, e.a, e.b, result, e.res);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL done_cycle op=%0d got %0d expected %0d", e.op, cyc, e.cyc);
          end
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done got %b expected 0", busy);
          end
          last_res = e.res;
        end
      end else if (exp_q.size() != 0 && cyc < exp_q[0].cyc) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_window cycle %0d got %b expected 1", cyc, busy);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic special;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
    special = (o >= 3'd4) && ((b == 32'd0) ||
              ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    e.res = ref_model(o, a, b);
    e.cyc = cyc + (special ? 1 : 33);
    e.op = o; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout waiting for done, %0d pending", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    wait_drain();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the arithmetic rules
    run(OP_MUL,    32'd7,          32'hFFFF_FFFD);
    run(OP_MULH,   32'h8000_0000,  32'h8000_0000);
    run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run(OP_DIV,    32'hFFFF_FFF9,  32'd2);
    run(OP_REM,    32'hFFFF_FFF9,  32'd2);
    run(OP_DIVU,   32'd100,        32'd7);
    run(OP_REMU,   32'd100,        32'd7);
    run(OP_DIV,    32'd5,          32'd0);
    run(OP_REM,    32'd5,          32'd0);
    run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
    run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
    run(OP_MUL,    32'h1234_5678,  32'h9ABC_DEF0);

    // Kill during CALC: no done, result kept
    @(negedge clk);
    start = 1'b1; op = OP_MUL; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_result", result, last_res);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("kill_no_done", 32'(dcount), 32'd0);
    check("kill_result_held", result, last_res);
    run(OP_DIVU, 32'd9, 32'd3);

    // Start with kill in IDLE is dropped
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = OP_DIVU; src_a = 32'd8; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("start_kill_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("start_kill_result", result, last_res);

    // Start and operand changes during CALC are ignored
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd77; src_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Randomized mix
    for (int i = 0; i < 200; i++) begin
      run(3'($urandom), pick(), pick());
    end

    // Asynchronous reset mid-CALC
    run(OP_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; src_a = 32'd11; src_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = 32'd0;
    run(OP_REMU, 32'd100, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
